// File: rtl/cmos_delay_pkg.sv
// cmos_delay_pkg -- shared timing constants and helpers for the delayed-register
// primitives (dffr_vec_delay, pipe_reg_delay).
//   TCQ_DEFAULT      default clock/reset-to-Q delay in time units
//   TPD_MIN/TYP/MAX  gate-delay triple (8:8:9) for delayed combinational cells
//   popcount()       number of set bits in a vector of up to POPCNT_W bits
package cmos_delay_pkg;

  localparam int TCQ_DEFAULT = 15;
  localparam int TPD_MIN     = 8;
  localparam int TPD_TYP     = 8;
  localparam int TPD_MAX     = 9;

  // Callers zero-extend narrower vectors to this width.
  localparam int POPCNT_W    = 64;

  function automatic int unsigned popcount(input logic [POPCNT_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_W; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/dffr_vec_delay.sv
// dffr_vec_delay -- W-bit register with async active-low reset, synchronous
// clear and enable; every update lands TCQ after the triggering edge.
//   clk_i   rising-edge clock
//   rst_ni  async reset, active low (output cleared TCQ after the fall)
//   en_i    capture enable; 0 holds
//   clr_i   synchronous clear, overrides en_i
//   d_i     data in
//   q_o     registered data out
module dffr_vec_delay
  import cmos_delay_pkg::*;
#(
  parameter int W   = 9,
  parameter int TCQ = TCQ_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Delayed NBAs model clock-to-Q; synthesis drops the delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    q_q <= #TCQ '0;
    else if (clr_i) q_q <= #TCQ '0;
    else if (en_i)  q_q <= #TCQ d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_reg_delay.sv
// pipe_reg_delay -- DEPTH-stage, WIDTH-bit pipeline register with per-stage
// valid, stall (EN=0) and synchronous flush (CLR), clock-to-Q delay TCQ.
//   C        rising-edge clock
//   RN       async reset, active low
//   EN       advance enable; 0 stalls every stage
//   CLR      synchronous flush of all stages, wins over EN
//   VI, D    input beat (valid, data)
//   VO, Q    last-stage beat
//   TOGGLES  saturating count of bit flips on {VO,Q}
// Build option: define PIPE_REG_TOGGLE_CNT_EN to build the toggle counter;
// otherwise TOGGLES is tied to 0. Supports WIDTH <= 63.
module pipe_reg_delay
  import cmos_delay_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int TCQ   = TCQ_DEFAULT,
  parameter int CNTW  = 16
) (
  input  logic             C,
  input  logic             RN,
  input  logic             EN,
  input  logic             CLR,
  input  logic             VI,
  input  logic [WIDTH-1:0] D,
  output logic             VO,
  output logic [WIDTH-1:0] Q,
  output logic [CNTW-1:0]  TOGGLES
);

  localparam int SW = WIDTH + 1;  // {valid, data}

  // stg[0] is the incoming beat, stg[k] the output of stage k-1.
  logic [DEPTH:0][SW-1:0] stg;

  assign stg[0] = {VI, D};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dffr_vec_delay #(.W(SW), .TCQ(TCQ)) u_stage (
      .clk_i  (C),
      .rst_ni (RN),
      .en_i   (EN),
      .clr_i  (CLR),
      .d_i    (stg[k]),
      .q_o    (stg[k+1])
    );
  end

  assign {VO, Q} = stg[DEPTH];

`ifdef PIPE_REG_TOGGLE_CNT_EN
  localparam logic [CNTW-1:0] TOG_MAX = '1;

  logic [SW-1:0]      last_d;
  logic [CNTW+31:0]   sum;
  logic [CNTW-1:0]    tog_q, tog_d;

  // Predict the last stage's next value so the count lands with Q.
  // Stage outputs are settled by the edge as long as TCQ < clock period.
  always_comb begin
    last_d = stg[DEPTH];
    if (CLR)     last_d = '0;
    else if (EN) last_d = stg[DEPTH-1];
    sum   = (CNTW+32)'(tog_q)
          + (CNTW+32)'(popcount(POPCNT_W'(stg[DEPTH] ^ last_d)));
    tog_d = (sum > (CNTW+32)'(TOG_MAX)) ? TOG_MAX : sum[CNTW-1:0];
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) tog_q <= #TCQ '0;
    else     tog_q <= #TCQ tog_d;
  end

  assign TOGGLES = tog_q;
`else
  assign TOGGLES = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_delay.sv
// tb_pipe_reg_delay -- drives two pipe_reg_delay instances from shared inputs
// (DEPTH=3/CNTW=16 and DEPTH=1/CNTW=4) and compares both against a queue model.
module tb_pipe_reg_delay;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int TCQ   = 15;

  logic             C, RN, EN, CLR, VI;
  logic [WIDTH-1:0] D;
  logic             VO, VO1;
  logic [WIDTH-1:0] Q, Q1;
  logic [15:0]      TG;
  logic [3:0]       TG1;

  pipe_reg_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TCQ(TCQ), .CNTW(16)) u_dut (
    .C(C), .RN(RN), .EN(EN), .CLR(CLR), .VI(VI), .D(D),
    .VO(VO), .Q(Q), .TOGGLES(TG)
  );

  pipe_reg_delay #(.WIDTH(WIDTH), .DEPTH(1), .TCQ(TCQ), .CNTW(4)) u_dut1 (
    .C(C), .RN(RN), .EN(EN), .CLR(CLR), .VI(VI), .D(D),
    .VO(VO1), .Q(Q1), .TOGGLES(TG1)
  );

  initial C = 1'b0;
  always #20 C = ~C;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each pipe is a queue of {valid,data}, back = output.
  logic [WIDTH:0] ma[$];
  logic [WIDTH:0] mb[$];
  int unsigned    tga, tgb;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_reset();
    ma = {};
    mb = {};
    for (int i = 0; i < DEPTH; i++) ma.push_back('0);
    mb.push_back('0);
    tga = 0;
    tgb = 0;
  endtask

  task automatic m_edge(input bit en, input bit clr, input bit vi, input logic [WIDTH-1:0] d);
    logic [WIDTH:0] oa, ob;
    oa = ma[$];
    ob = mb[$];
    if (clr) begin
      foreach (ma[i]) ma[i] = '0;
      foreach (mb[i]) mb[i] = '0;
    end else if (en) begin
      ma.push_front({vi, d}); void'(ma.pop_back());
      mb.push_front({vi, d}); void'(mb.pop_back());
    end
    tga = sat(tga + $countones(oa ^ ma[$]), 16'hFFFF);
    tgb = sat(tgb + $countones(ob ^ mb[$]), 4'hF);
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH:0] ea, eb;
    ea = ma[$];
    eb = mb[$];
    chk({tag, ".vo"},  32'(VO),  32'(ea[WIDTH]));
    chk({tag, ".q"},   32'(Q),   32'(ea[WIDTH-1:0]));
    chk({tag, ".vo1"}, 32'(VO1), 32'(eb[WIDTH]));
    chk({tag, ".q1"},  32'(Q1),  32'(eb[WIDTH-1:0]));
`ifdef PIPE_REG_TOGGLE_CNT_EN
    chk({tag, ".tg"},  32'(TG),  tga);
    chk({tag, ".tg1"}, 32'(TG1), tgb);
`else
    chk({tag, ".tg"},  32'(TG),  32'd0);
    chk({tag, ".tg1"}, 32'(TG1), 32'd0);
`endif
  endtask

  // Called just after a negedge: drive, take one posedge, check after the next negedge.
  task automatic cyc(input bit en, input bit clr, input bit vi, input logic [WIDTH-1:0] d,
                     input string tag);
    EN = en; CLR = clr; VI = vi; D = d;
    @(posedge C);
    if (RN) m_edge(en, clr, vi, d);
    @(negedge C); #1;
    check_all(tag);
  endtask

  initial begin
    RN = 1'b1; EN = 1'b0; CLR = 1'b0; VI = 1'b0; D = '0;
    m_reset();

    // Async reset mid-cycle, no clock edge involved.
    #3 RN = 1'b0;
    #(TCQ + 1);
    check_all("rst_async");
    repeat (2) begin
      EN = 1'b1; VI = 1'b1; D = 8'h77;
      @(posedge C); #(TCQ + 1);
      check_all("rst_hold");
    end
    @(negedge C); #1;
    RN = 1'b1;

    // Latency.
    cyc(1, 0, 1, 8'hA5, "lat1");
    cyc(1, 0, 1, 8'h3C, "lat2");
    cyc(1, 0, 0, 8'h00, "lat3");
    chk("lat3_q",  32'(Q),  32'hA5);
    chk("lat3_vo", 32'(VO), 32'd1);
    cyc(1, 0, 0, 8'h00, "lat4");
    chk("lat4_q",  32'(Q),  32'h3C);

    // Stall: A5 emerges two edges late.
    repeat (DEPTH) cyc(1, 0, 0, 8'h00, "drain");
    cyc(1, 0, 1, 8'hA5, "stl_in");
    cyc(0, 0, 0, 8'h00, "stl_0");
    cyc(0, 0, 0, 8'h00, "stl_1");
    chk("stl_vo_hold", 32'(VO), 32'd0);
    cyc(1, 0, 0, 8'h00, "stl_2");
    chk("stl_not_yet", 32'(VO), 32'd0);
    cyc(1, 0, 0, 8'h00, "stl_3");
    chk("stl_out_q",  32'(Q),  32'hA5);
    chk("stl_out_vo", 32'(VO), 32'd1);

    // Flush with EN=1.
    cyc(1, 0, 1, 8'h11, "fl_a");
    cyc(1, 0, 1, 8'h22, "fl_b");
    cyc(1, 1, 1, 8'h33, "fl_clr");
    chk("fl_vo", 32'(VO), 32'd0);
    chk("fl_q",  32'(Q),  32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, 8'($urandom), "fl_after");
      chk("fl_after_vo", 32'(VO), 32'd0);
    end

    // Reset mid-flight discards everything.
    cyc(1, 0, 1, 8'h5A, "mid_a");
    cyc(1, 0, 1, 8'hC3, "mid_b");
    #5 RN = 1'b0;
    m_reset();
    #(TCQ + 1);
    check_all("rst_mid");
    @(negedge C); #1;
    RN = 1'b1;

    // Toggle counter on the DEPTH=1, CNTW=4 instance.
    cyc(1, 0, 1, 8'hFF, "tg_a");
`ifdef PIPE_REG_TOGGLE_CNT_EN
    chk("tg_first9", 32'(TG1), 32'd9);
`endif
    cyc(1, 0, 1, 8'h00, "tg_b");
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, (i % 2) ? 8'h00 : 8'hFF, "tg_alt");
`ifdef PIPE_REG_TOGGLE_CNT_EN
    chk("tg_sat", 32'(TG1), 32'hF);
`else
    chk("tg_off", 32'(TG1), 32'd0);
`endif
    #5 RN = 1'b0;
    m_reset();
    #(TCQ + 1);
    chk("tg_rst", 32'(TG1), 32'd0);
    @(negedge C); #1;
    RN = 1'b1;

    // Collision: RN falls in the posedge timestep.
    cyc(1, 0, 1, 8'h42, "col_pre");
    EN = 1'b1; CLR = 1'b0; VI = 1'b1; D = 8'hFF;
    @(posedge C);
    RN = 1'b0;
    m_reset();
    @(negedge C); #1;
    check_all("col");
    chk("col_q", 32'(Q1), 32'd0);
    RN = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      cyc(1, 0, 0, 8'h00, "col_after");
      chk("col_noff", 32'(Q == 8'hFF), 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(3) != 0, $urandom_range(9) == 0, 1'($urandom),
          8'($urandom), "rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end

endmodule
